// File: rtl/uart_baud_generator.sv
// rtl/uart_baud_generator.sv - fractional-N UART sample/bit tick generator
// SET_BAUD recomputes the divisor with a sequential restoring divider, one quotient bit per cycle.
module uart_baud_generator #(
  parameter int unsigned CLK_HZ       = 25_000_000,
  parameter int unsigned DEFAULT_BAUD = 250_000,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned FRAC_BITS    = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                           physical_clock,
  input  logic                           reset,
  input  logic [2:0]                     instruction,
  input  logic [31:0]                    baudrate_value,
  output logic                           ready,
  output logic                           cfg_done,
  output logic                           cfg_error,
  output logic                           running,
  output logic                           sample_tick,
  output logic                           bit_tick,
  output logic                           uart_clock,
  output logic [31:0]                    bit_count,
  output logic [CNT_WIDTH+FRAC_BITS-1:0] divisor
);
  localparam int QW  = CNT_WIDTH + FRAC_BITS;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int DW  = 32 + OSW;
  localparam int RW  = DW + 1;
  localparam int CW  = $clog2(QW);

  localparam logic [QW-1:0]  ONE         = QW'(1) << FRAC_BITS;
  localparam logic [QW-1:0]  MIN_DIV     = ONE << 1;
  localparam logic [QW-1:0]  NUM         = QW'(CLK_HZ) << FRAC_BITS;
  localparam logic [63:0]    DEF_DEN     = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
  localparam logic [QW-1:0]  DEFAULT_DIV = QW'((64'(CLK_HZ) << FRAC_BITS) / DEF_DEN);
  localparam logic [OSW-1:0] OS_LAST     = OSW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_COMMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_rem;
  logic [QW-1:0]   r_quo;
  logic [DW-1:0]   r_den;
  logic            r_zero;
  logic [QW-1:0]   r_div;
  logic [QW-1:0]   r_acc;
  logic [OSW-1:0]  r_sub;
  logic            r_uclk;
  logic [31:0]     r_bits;
  logic            r_run;
  logic            r_err;

  logic            w_accept, w_set, w_start, w_stop, w_resync;
  logic [RW-1:0]   w_trial;
  logic [DW-1:0]   w_diff;
  logic            w_fits, w_valid, w_commit_ok, w_hit;
  logic [QW-1:0]   w_acc_inc;

  assign w_accept = ready && instruction[2];
  assign w_set    = w_accept && (instruction[1:0] == 2'b00);
  assign w_start  = w_accept && (instruction[1:0] == 2'b01);
  assign w_stop   = w_accept && (instruction[1:0] == 2'b10);
  assign w_resync = w_accept && (instruction[1:0] == 2'b11);

  // Remainder stays below the denominator, so the difference fits in DW bits.
  assign w_trial     = {r_rem, r_quo[QW-1]};
  assign w_diff      = w_trial[DW-1:0] - r_den;
  assign w_fits      = !r_zero && (w_trial >= {1'b0, r_den});
  assign w_valid     = !r_zero && (r_quo >= MIN_DIV);
  assign w_commit_ok = cfg_done && w_valid;

  assign w_acc_inc   = r_acc + ONE;
  assign w_hit       = r_run && (w_acc_inc >= r_div);
  assign sample_tick = w_hit;
  assign bit_tick    = w_hit && (r_sub == OS_LAST);

  always_ff @(posedge physical_clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    cfg_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (instruction == 3'b100) w_next = S_DIV;
      end
      S_DIV:    if (r_cnt == CW'(QW - 1)) w_next = S_COMMIT;
      S_COMMIT: begin
        cfg_done = 1'b1;
        w_next   = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge physical_clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_zero <= 1'b0;
    end else if (w_set) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= NUM;
      r_den  <= {baudrate_value, OSW'(0)};
      r_zero <= (baudrate_value == 32'd0);
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_fits) begin
        r_rem <= w_diff;
        r_quo <= {r_quo[QW-2:0], 1'b1};
      end else begin
        r_rem <= w_trial[DW-1:0];
        r_quo <= {r_quo[QW-2:0], 1'b0};
      end
    end
  end

  // A valid commit or RESYNC restarts the bit phase; otherwise the engine advances only while running.
  always_ff @(posedge physical_clock) begin
    if (reset) begin
      r_div  <= DEFAULT_DIV;
      r_run  <= 1'b1;
      r_err  <= 1'b0;
      r_acc  <= '0;
      r_sub  <= '0;
      r_uclk <= 1'b0;
      r_bits <= '0;
    end else begin
      if (w_start)     r_run <= 1'b1;
      else if (w_stop) r_run <= 1'b0;
      if (cfg_done) r_err <= !w_valid;
      if (w_commit_ok) begin
        r_div  <= r_quo;
        r_acc  <= '0;
        r_sub  <= '0;
        r_bits <= '0;
      end else if (w_resync) begin
        r_acc  <= '0;
        r_sub  <= '0;
        r_bits <= '0;
      end else if (r_run) begin
        r_acc <= w_hit ? (w_acc_inc - r_div) : w_acc_inc;
        if (w_hit) r_sub <= r_sub + OSW'(1);
        if (bit_tick) begin
          r_uclk <= ~r_uclk;
          r_bits <= r_bits + 32'd1;
        end
      end
    end
  end

  assign running    = r_run;
  assign cfg_error  = r_err;
  assign uart_clock = r_uclk;
  assign bit_count  = r_bits;
  assign divisor    = r_div;

endmodule

// File: doc/uart_baud_generator.md
# uart_baud_generator

Parametrised successor to the UART clock generator: produces a fractional-N oversampling tick, a bit tick and a square `uart_clock` from `physical_clock` for any programmable baud rate. The divisor is computed on-chip by a sequential restoring divider, so there is no combinational divide. Commands use the existing 3-bit instruction bus. Sits between the system clock and the UART TX/RX shift engines; RX uses `RESYNC` to phase-align on start-bit detection.

## Interface
- `CLK_HZ`, 25_000_000: `physical_clock` frequency; must be < 2^CNT_WIDTH.
- `DEFAULT_BAUD`, 250_000: baud rate loaded at reset.
- `OVERSAMPLE`, 16: sample ticks per bit; power of two, ≥ 2.
- `FRAC_BITS`, 4: fractional bits of divisor/accumulator.
- `CNT_WIDTH`, 32: integer width; QW = CNT_WIDTH+FRAC_BITS.
- `physical_clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 3: 3'b100 SET_BAUD, 3'b101 START, 3'b110 STOP, 3'b111 RESYNC, others NOP; sampled every cycle.
- `baudrate_value` in 32: baud for SET_BAUD, captured in the accept cycle.
- `ready` out 1: commands accepted only when 1.
- `cfg_done` out 1: one-cycle pulse when a SET_BAUD completes.
- `cfg_error` out 1: last SET_BAUD rejected; level.
- `running` out 1: tick generation enabled.
- `sample_tick` out 1: one-cycle pulse at OVERSAMPLE×baud average rate.
- `bit_tick` out 1: one-cycle pulse at baud rate.
- `uart_clock` out 1: toggles on every `bit_tick`.
- `bit_count` out 32: `bit_tick` count since reset/RESYNC/commit; wraps at 2^32.
- `divisor` out QW: active divisor D, fixed-point with FRAC_BITS fraction bits.

## Operation
- ONE = 2^FRAC_BITS. D = floor(CLK_HZ·ONE / (baud·OVERSAMPLE)). DEFAULT_DIV is a constant computed from DEFAULT_BAUD.
- Reset: `divisor`=DEFAULT_DIV, `running`=1, `ready`=1. All other outputs 0. Accumulator `acc`=0. Sample counter `sub`=0. Any division in progress is aborted with no `cfg_done`.
- Tick engine, per cycle while `running`:
  - a = acc+ONE.
  - If a ≥ D: `sample_tick`=1 and acc=a−D. Otherwise acc=a.
- On each `sample_tick`, `sub` increments modulo OVERSAMPLE. `bit_tick` is asserted with the `sample_tick` where `sub`=OVERSAMPLE−1. On that same cycle `uart_clock` toggles and `bit_count` increments.
- Controller states:
  - IDLE (`ready`=1) → DIV on accepted SET_BAUD.
  - DIV: restoring division, one quotient bit per cycle, QW cycles. The tick engine keeps running on the old D.
  - DIV → COMMIT → IDLE.
- COMMIT (one cycle): `cfg_done`=1.
  - Valid result: load D, clear `acc`, `sub` and `bit_count`, and clear `cfg_error`.
  - Invalid result: set `cfg_error`; D and counters are unchanged.
- Invalid means baud=0 or D < 2·ONE, i.e. the sample rate exceeds CLK_HZ/2. Baud=0 skips the divider arithmetic but keeps identical timing.
- START/STOP set/clear `running`.
  - STOP freezes `acc`, `sub`, `uart_clock` and `bit_count`; ticks are 0 while stopped.
  - START resumes from the frozen state. Both act from the next cycle.
- RESYNC clears `acc`, `sub` and `bit_count`; no tick in the following cycle. `uart_clock` and `running` are unchanged.
- All commands, including RESYNC, are ignored while `ready`=0.

## Timing
- Command accepted in cycle T (`ready`=1). START/STOP/RESYNC take effect at T+1; `ready` stays 1.
- SET_BAUD:
  - `ready`=0 for cycles T+1 … T+QW+1.
  - `cfg_done` pulses at T+QW+1, and the new D governs ticks from T+QW+2.
  - `ready`=1 again at T+QW+2.
- Sample period alternates between floor(D/ONE) and ceil(D/ONE) clocks; the long-run average is exactly D/ONE.
- The first `sample_tick` after a clear occurs at cycle floor(D/ONE) or floor(D/ONE)+1 relative to the clear.
- Integer D/ONE gives an exact period.
- `reset` overrides everything in its cycle.

## Test plan
- **Reset defaults** (25 MHz, 250 kbaud, OS 16, FRAC 4): D=100. Sample periods repeat 7,6,6,6. `bit_tick` every 100 cycles, `uart_clock` period 200 cycles, `bit_count`=10 after 1000 cycles.
- **SET_BAUD 156_250**:
  - `ready` low 37 cycles, `cfg_done` at T+37, `divisor`=160.
  - Then `sample_tick` every 10 cycles and `bit_tick` every 160; `bit_count` restarts at 0.
- **Invalid baud**:
  - SET_BAUD 0 → `cfg_error`=1, `divisor` stays 100, ticks undisturbed.
  - SET_BAUD 1_000_000 (D=25 < 32) → `cfg_error`=1.
  - A subsequent valid SET_BAUD clears `cfg_error`.
- **STOP/START**: STOP at mid-bit freezes all counters and `uart_clock` for 50 cycles. After START the remaining bit time is exactly the unelapsed portion, and no tick is lost or duplicated.
- **RESYNC** with D=160, issued mid-bit: next `bit_tick` exactly 160 cycles after the accept cycle, `bit_count`=0→1. RESYNC issued while `ready`=0 is ignored.
- **Reset mid-division**: assert `reset` at T+10 of SET_BAUD 9600 → no `cfg_done`, `divisor`=100, `ready`=1 the cycle after reset deasserts.
